// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: one outstanding access, request/grant/response memory port,
// byte-lane alignment of store data and sign/zero extension of load data.
module ysyx_23060184_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_W-1:0]     req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    // state  | meaning
    // S_IDLE | ready for a new request
    // S_REQ  | memory request asserted, waiting for grant
    // S_WAIT | load granted, waiting for read data
    // S_RESP | response presented until consumed
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [OFF_W-1:0]    req_off;
    logic                req_misaligned;
    logic                req_illegal;
    logic [STRB_W-1:0]   strb_base;
    logic [STRB_W-1:0]   req_strb;
    logic [DATA_W-1:0]   req_wdata_sh;

    logic [OFF_W-1:0]    rd_off;
    logic [DATA_W-1:0]   rd_sh;
    logic [DATA_W-1:0]   load_data;

    assign req_off = req_addr[OFF_W-1:0];

    always_comb begin
        req_misaligned = 1'b0;
        strb_base      = '0;
        case (req_size)
            2'd0: begin
                req_misaligned = 1'b0;
                strb_base      = STRB_W'(1);
            end
            2'd1: begin
                req_misaligned = req_addr[0];
                strb_base      = STRB_W'(3);
            end
            2'd2: begin
                req_misaligned = |req_addr[1:0];
                strb_base      = STRB_W'(15);
            end
            default: begin
                req_misaligned = |req_addr[2:0];
                strb_base      = '1;
            end
        endcase
    end

    // A dword on a 32-bit bus cannot be expressed in one beat.
    assign req_illegal  = req_misaligned || ((req_size == 2'd3) && (DATA_W == 32));
    assign req_strb     = strb_base << req_off;
    assign req_wdata_sh = req_wdata << {req_off, 3'b000};

    assign rd_off = addr_q[OFF_W-1:0];
    assign rd_sh  = mem_rdata >> {rd_off, 3'b000};

    // Signed size-casts sign-extend; dword loads pass through untouched.
    always_comb begin
        load_data = rd_sh;
        case (size_q)
            2'd0: load_data = uns_q ? DATA_W'(rd_sh[7:0])  : DATA_W'($signed(rd_sh[7:0]));
            2'd1: load_data = uns_q ? DATA_W'(rd_sh[15:0]) : DATA_W'($signed(rd_sh[15:0]));
            2'd2: load_data = uns_q ? DATA_W'(rd_sh[31:0]) : DATA_W'($signed(rd_sh[31:0]));
            default: load_data = rd_sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata_sh;
                    wstrb_d = req_we ? req_strb : '0;
                    rdata_d = '0;
                    err_d   = req_illegal;
                    state_d = req_illegal ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = we_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = load_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;
    assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_we    = we_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;

endmodule
